// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the initiator FSM state type.
// Used by the master, the slave and the verification models.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRsp
  } axi_m_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out,
// one response back. All outputs come from registers or a decode of the state register.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP
);

  axi_m_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  aw_done_nxt, w_done_nxt;

  // In WR_REQ each VALID equals !done, so done|READY is exactly "handshake seen".
  assign aw_done_nxt = aw_done_q | AWREADY;
  assign w_done_nxt  = w_done_q | WREADY;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
          state_d = cmd_write ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        if (aw_done_nxt && w_done_nxt) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end else begin
          aw_done_d = aw_done_nxt;
          w_done_d  = w_done_nxt;
        end
      end
      StWrResp: begin
        if (BVALID) begin
          resp_d  = BRESP;
          rdata_d = '0;
          state_d = StRsp;
        end
      end
      StRdReq: begin
        if (ARREADY) state_d = StRdResp;
      end
      StRdResp: begin
        if (RVALID) begin
          resp_d  = RRESP;
          rdata_d = RDATA;
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered so cmd_ready stays low while ARESETN is asserted.
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_q      <= RESP_OKAY;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign AWVALID   = (state_q == StWrReq) && !aw_done_q;
  assign WVALID    = (state_q == StWrReq) && !w_done_q;
  assign BREADY    = (state_q == StWrResp);
  assign ARVALID   = (state_q == StRdReq);
  assign RREADY    = (state_q == StRdResp);
  assign rsp_valid = (state_q == StRsp);
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule
